// File: rtl/tape_rec_if.sv
// RAM write port of the cassette recorder: one outstanding byte write,
// with address/data/we held until the RAM pulses mem_ready.
interface tape_rec_if;
  logic [24:0] mem_addr;
  logic [7:0]  mem_dout;
  logic        mem_we;
  logic        mem_ready;

  modport master (output mem_addr, output mem_dout, output mem_we, input mem_ready);
  modport slave  (input mem_addr, input mem_dout, input mem_we, output mem_ready);
endinterface

// File: rtl/tape_rec.sv
// Cassette recorder: measures cass_write periods in ce_1m ticks, encodes them as TAP v1 bytes,
// streams them to RAM and finally writes the 20-byte TAP header. Option: TAPE_REC_MOTOR_GATE_EN.
module tape_rec #(
  parameter logic [24:0] BASE_ADDR  = 25'h0,
  parameter logic [24:0] MAX_BYTES  = 25'h0FFFEC,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_1m,
  input  logic        cass_write,
  input  logic        cass_motor_n,
  input  logic        rec_start,
  input  logic        rec_stop,
  tape_rec_if.master  mem,
  output logic        rec_active,
  output logic [24:0] rec_len,
  output logic        overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_REC, S_DRAIN, S_HDR} state_t;
  state_t r_state, w_state_next;

  logic        r_cw_s1, r_cw_s2, r_cw_d;
  logic [23:0] r_period;
  logic        r_armed;
  logic        r_enc_valid;
  logic [23:0] r_enc_p;
  logic [1:0]  r_enc_idx;
  logic        r_pend_valid;
  logic [23:0] r_pend_p;
  logic [7:0]  r_fifo_mem [FIFO_DEPTH];
  logic [AW:0] r_wr_ptr, r_rd_ptr;
  logic        r_mem_we;
  logic [24:0] r_mem_addr;
  logic [7:0]  r_mem_dout;
  logic [24:0] r_rec_len;
  logic        r_overflow;
  logic [4:0]  r_hdr_idx;

  logic        w_motor_on, w_tick, w_edge, w_capture, w_start;
  logic        w_enc_short, w_enc_last, w_enc_free, w_push_ok;
  logic [7:0]  w_enc_byte, w_hdr_byte;
  logic [AW:0] w_count;
  logic        w_empty, w_full, w_room;
  logic [25:0] w_total;
  logic [31:0] w_len32;

`ifdef TAPE_REC_MOTOR_GATE_EN
  assign w_motor_on = ~cass_motor_n;
`else
  logic w_unused_motor;
  assign w_unused_motor = cass_motor_n;
  assign w_motor_on     = 1'b1;
`endif

  assign w_tick    = ce_1m & w_motor_on;
  assign w_edge    = r_cw_s2 & ~r_cw_d & w_motor_on & (r_state == S_REC);
  assign w_capture = w_edge & r_armed;
  assign w_start   = (r_state == S_IDLE) & rec_start;

  // Bytes already committed plus bytes still queued decide when capacity is hit.
  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_empty = (w_count == '0);
  assign w_full  = (w_count == DEPTH_L);
  assign w_total = {1'b0, r_rec_len} + 26'(w_count);
  assign w_room  = (w_total < {1'b0, MAX_BYTES});

  assign w_enc_short = (r_enc_p[23:11] == '0);
  assign w_enc_last  = r_enc_valid & (w_enc_short | (r_enc_idx == 2'd3));
  assign w_enc_free  = ~r_enc_valid | w_enc_last;
  assign w_push_ok   = r_enc_valid & ~w_full & w_room;

  always_comb begin
    w_enc_byte = 8'h00;
    if (w_enc_short) begin
      w_enc_byte = (r_enc_p[10:3] == 8'h00) ? 8'h01 : r_enc_p[10:3];
    end else begin
      case (r_enc_idx)
        2'd0:    w_enc_byte = 8'h00;
        2'd1:    w_enc_byte = r_enc_p[7:0];
        2'd2:    w_enc_byte = r_enc_p[15:8];
        default: w_enc_byte = r_enc_p[23:16];
      endcase
    end
  end

  always_comb begin
    w_len32    = {7'd0, r_rec_len};
    w_hdr_byte = 8'h00;
    case (r_hdr_idx)
      5'd0:  w_hdr_byte = 8'h43;
      5'd1:  w_hdr_byte = 8'h36;
      5'd2:  w_hdr_byte = 8'h34;
      5'd3:  w_hdr_byte = 8'h2D;
      5'd4:  w_hdr_byte = 8'h54;
      5'd5:  w_hdr_byte = 8'h41;
      5'd6:  w_hdr_byte = 8'h50;
      5'd7:  w_hdr_byte = 8'h45;
      5'd8:  w_hdr_byte = 8'h2D;
      5'd9:  w_hdr_byte = 8'h52;
      5'd10: w_hdr_byte = 8'h41;
      5'd11: w_hdr_byte = 8'h57;
      5'd12: w_hdr_byte = 8'h01;
      5'd16: w_hdr_byte = w_len32[7:0];
      5'd17: w_hdr_byte = w_len32[15:8];
      5'd18: w_hdr_byte = w_len32[23:16];
      5'd19: w_hdr_byte = w_len32[31:24];
      default: w_hdr_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (rec_start) w_state_next = S_REC;
      S_REC:   if (rec_stop || !w_room) w_state_next = S_DRAIN;
      // The encoder may still hold bytes of a period captured just before stop.
      S_DRAIN: if (w_empty && !r_mem_we && !r_enc_valid && !r_pend_valid) w_state_next = S_HDR;
      S_HDR:   if (r_mem_we && mem.mem_ready && r_hdr_idx == 5'd19) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cw_s1 <= 1'b0; r_cw_s2 <= 1'b0; r_cw_d <= 1'b0;
      r_period <= '0; r_armed <= 1'b0;
      r_enc_valid <= 1'b0; r_enc_p <= '0; r_enc_idx <= '0;
      r_pend_valid <= 1'b0; r_pend_p <= '0;
      r_wr_ptr <= '0; r_overflow <= 1'b0;
    end else begin
      r_cw_s1 <= cass_write;
      r_cw_s2 <= r_cw_s1;
      r_cw_d  <= r_cw_s2;
      if (w_start) begin
        r_period <= '0; r_armed <= 1'b0;
        r_enc_valid <= 1'b0; r_enc_idx <= '0; r_pend_valid <= 1'b0;
        r_wr_ptr <= '0; r_overflow <= 1'b0;
      end else begin
        if (r_state == S_REC) begin
          if (w_edge) begin
            r_armed  <= 1'b1;
            r_period <= {23'd0, w_tick};
          end else if (w_tick && r_period != '1) begin
            r_period <= r_period + 24'd1;
          end
        end
        if (r_enc_valid && !w_enc_last) r_enc_idx <= r_enc_idx + 2'd1;
        // A finishing sequence hands over to the pending period first, then to a fresh capture.
        if (w_enc_free) begin
          r_enc_idx <= '0;
          if (r_pend_valid) begin
            r_enc_valid  <= 1'b1;
            r_enc_p      <= r_pend_p;
            r_pend_valid <= w_capture;
            r_pend_p     <= r_period;
          end else begin
            r_enc_valid <= w_capture;
            r_enc_p     <= r_period;
          end
        end else if (w_capture) begin
          if (!r_pend_valid) begin
            r_pend_valid <= 1'b1;
            r_pend_p     <= r_period;
          end else begin
            r_overflow <= 1'b1;
          end
        end
        if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
        if ((r_enc_valid && !w_push_ok) || (r_state == S_REC && !w_room)) r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_fifo_mem[r_wr_ptr[AW-1:0]] <= w_enc_byte;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem_we <= 1'b0; r_mem_addr <= '0; r_mem_dout <= '0;
      r_rec_len <= '0; r_rd_ptr <= '0; r_hdr_idx <= '0;
    end else if (w_start) begin
      r_rec_len <= '0; r_rd_ptr <= '0; r_hdr_idx <= '0; r_mem_we <= 1'b0;
    end else if (r_mem_we) begin
      if (mem.mem_ready) begin
        r_mem_we <= 1'b0;
        if (r_state == S_HDR) begin
          r_hdr_idx <= r_hdr_idx + 5'd1;
        end else begin
          r_rec_len <= r_rec_len + 25'd1;
          r_rd_ptr  <= r_rd_ptr + PTR_ONE;
        end
      end
    end else if ((r_state == S_REC || r_state == S_DRAIN) && !w_empty) begin
      r_mem_we   <= 1'b1;
      r_mem_addr <= BASE_ADDR + 25'd20 + r_rec_len;
      r_mem_dout <= r_fifo_mem[r_rd_ptr[AW-1:0]];
    end else if (r_state == S_HDR) begin
      r_mem_we   <= 1'b1;
      r_mem_addr <= BASE_ADDR + {20'd0, r_hdr_idx};
      r_mem_dout <= w_hdr_byte;
    end
  end

  assign mem.mem_we   = r_mem_we;
  assign mem.mem_addr = r_mem_addr;
  assign mem.mem_dout = r_mem_dout;
  assign rec_active   = (r_state != S_IDLE);
  assign rec_len      = r_rec_len;
  assign overflow     = r_overflow;
endmodule

// File: tb/tb_tape_rec.sv
// Scoreboard bench for tape_rec: expected RAM writes are queued as edges/stops are driven
// and compared as the RAM model accepts each write.
module tb_tape_rec;
  localparam logic [24:0] BASE = 25'h1000;
  localparam logic [24:0] MAXB = 25'd12;
  localparam int          LAT  = 3;

  typedef struct packed { logic [24:0] addr; logic [7:0] data; } wr_t;

  logic        clk, reset, ce_1m, cass_write, cass_motor_n, rec_start, rec_stop;
  logic        rec_active, overflow;
  logic [24:0] rec_len;

  tape_rec_if mif();

  tape_rec #(.BASE_ADDR(BASE), .MAX_BYTES(MAXB), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .ce_1m(ce_1m), .cass_write(cass_write),
    .cass_motor_n(cass_motor_n), .rec_start(rec_start), .rec_stop(rec_stop),
    .mem(mif), .rec_active(rec_active), .rec_len(rec_len), .overflow(overflow)
  );

  int n_tests = 0, n_fail = 0;
  wr_t exp_q[$];
  logic [7:0] mem_img [int];
  int ce_div = 1, ce_cnt = 0;
  int data_cnt = 0, data_limit = 1000000, prev_gap = -1;
  bit cap_mode = 0, ready_en = 1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    ce_1m = 1'b0;
    forever begin
      step();
      ce_cnt++;
      if (ce_cnt >= ce_div) ce_cnt = 0;
      ce_1m = (ce_cnt == 0);
    end
  end

  // RAM model: answers each write LAT held clocks later and checks it against the scoreboard.
  initial begin
    logic [24:0] h_addr;
    logic [7:0]  h_data;
    bit holding;
    int wcnt;
    wr_t e;
    holding = 0; wcnt = 0; h_addr = '0; h_data = '0;
    mif.mem_ready = 1'b0;
    forever begin
      step();
      mif.mem_ready = 1'b0;
      if (mif.mem_we && !reset) begin
        if (!holding) begin
          holding = 1; wcnt = 0;
          h_addr = mif.mem_addr; h_data = mif.mem_dout;
        end
        if (ready_en) wcnt++;
        if (wcnt >= LAT) begin
          mif.mem_ready = 1'b1;
          holding = 0;
          $display("[TB] wr addr=%h data=%h", mif.mem_addr, mif.mem_dout);
          chk("hold_addr", 32'(mif.mem_addr), 32'(h_addr));
          chk("hold_data", 32'(mif.mem_dout), 32'(h_data));
          mem_img[int'(mif.mem_addr)] = mif.mem_dout;
          if (mif.mem_addr == BASE + 25'd19) chk("active_at_hdr19", 32'(rec_active), 32'd1);
          if (exp_q.size() == 0) begin
            chk("sb_extra", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("sb_addr", 32'(mif.mem_addr), 32'(e.addr));
            chk("sb_data", 32'(mif.mem_dout), 32'(e.data));
          end
        end
      end else begin
        holding = 0;
      end
    end
  end

  task automatic push_byte(input logic [7:0] b);
    if (data_cnt < data_limit) begin
      exp_q.push_back('{addr: BASE + 25'd20 + 25'(data_cnt), data: b});
      data_cnt++;
    end
  endtask

  task automatic push_period(input int p);
    logic [23:0] pv;
    logic [20:0] q;
    pv = (p > 32'hFFFFFF) ? 24'hFFFFFF : p[23:0];
    q  = pv[23:3];
    if (q == 0) push_byte(8'h01);
    else if (q <= 255) push_byte(q[7:0]);
    else begin
      push_byte(8'h00); push_byte(pv[7:0]); push_byte(pv[15:8]); push_byte(pv[23:16]);
    end
  endtask

  task automatic push_header(input int n);
    logic [7:0]  sig [12];
    logic [31:0] len;
    logic [7:0]  b;
    sig = '{8'h43, 8'h36, 8'h34, 8'h2D, 8'h54, 8'h41, 8'h50, 8'h45, 8'h2D, 8'h52, 8'h41, 8'h57};
    len = n;
    for (int k = 0; k < 20; k++) begin
      if (k < 12) b = sig[k];
      else if (k == 12) b = 8'h01;
      else if (k < 16) b = 8'h00;
      else b = len[8*(k-16) +: 8];
      exp_q.push_back('{addr: BASE + 25'(k), data: b});
    end
  endtask

  // Rising edge now; the next rising edge follows after gap clocks.
  task automatic edge_gap(input int gap);
    if (prev_gap > 0) push_period(prev_gap / ce_div);
    if (cap_mode && data_cnt == data_limit) begin
      push_header(data_cnt);
      cap_mode = 0;
    end
    cass_write = 1'b1;
    repeat (2) step();
    cass_write = 1'b0;
    repeat (gap - 2) step();
    prev_gap = gap;
  endtask

  task automatic start_rec(input bit with_stop);
    rec_start = 1'b1; rec_stop = with_stop;
    step();
    rec_start = 1'b0; rec_stop = 1'b0;
    data_cnt = 0; prev_gap = -1; data_limit = 1000000;
  endtask

  task automatic stop_rec();
    rec_stop = 1'b1;
    step();
    rec_stop = 1'b0;
    push_header(data_cnt);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20000 && rec_active; i++) step();
    chk("idle_reached", 32'(rec_active), 32'd0);
  endtask

  initial begin
    reset = 1'b1; cass_write = 1'b0; cass_motor_n = 1'b0; rec_start = 1'b0; rec_stop = 1'b0;
    #1;
    chk("rst_we", 32'(mif.mem_we), 32'd0);
    chk("rst_addr", 32'(mif.mem_addr), 32'd0);
    chk("rst_dout", 32'(mif.mem_dout), 32'd0);
    chk("rst_active", 32'(rec_active), 32'd0);
    chk("rst_len", 32'(rec_len), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    repeat (3) step();
    reset = 1'b0;
    step();

    // Two 400-tick periods; start and stop together in IDLE must start.
    start_rec(1);
    chk("start_wins", 32'(rec_active), 32'd1);
    edge_gap(400); edge_gap(400); edge_gap(20);
    stop_rec(); wait_idle();
    chk("t1_len", 32'(rec_len), 32'd2);

    // One long period of 5000 ticks.
    start_rec(0);
    edge_gap(5000); edge_gap(20);
    stop_rec(); wait_idle();
    chk("t2_len", 32'(rec_len), 32'd4);

    // Encoding boundaries: q==0, q==255, q==256.
    start_rec(0);
    edge_gap(5); edge_gap(2047); edge_gap(2048); edge_gap(20);
    stop_rec(); wait_idle();
    chk("t3_len", 32'(rec_len), 32'd6);
    chk("t3_ovf", 32'(overflow), 32'd0);

    // Tick every other clock: 800 clocks is 400 ticks.
    ce_div = 2;
    start_rec(0);
    edge_gap(800); edge_gap(800); edge_gap(20);
    stop_rec(); wait_idle();
    chk("t4_len", 32'(rec_len), 32'd2);
    ce_div = 1;

    // Three periods then header contents.
    start_rec(0);
    edge_gap(400); edge_gap(400); edge_gap(400); edge_gap(20);
    stop_rec(); wait_idle();
    chk("hdr0", 32'(mem_img[int'(BASE)]), 32'h43);
    chk("hdr11", 32'(mem_img[int'(BASE)+11]), 32'h57);
    chk("hdr12", 32'(mem_img[int'(BASE)+12]), 32'h01);
    chk("hdr16", 32'(mem_img[int'(BASE)+16]), 32'h03);
    chk("hdr17", 32'(mem_img[int'(BASE)+17]), 32'h00);
    chk("hdr18", 32'(mem_img[int'(BASE)+18]), 32'h00);
    chk("hdr19", 32'(mem_img[int'(BASE)+19]), 32'h00);

    // FIFO overflow while RAM stalls: nine periods, only eight survive.
    start_rec(0);
    data_limit = 8;
    ready_en = 0;
    for (int i = 0; i < 10; i++) edge_gap(80 + 8*i);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_nolen", 32'(rec_len), 32'd0);
    ready_en = 1;
    stop_rec(); wait_idle();
    chk("ovf_len", 32'(rec_len), 32'd8);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Capacity: twelve bytes force the stop; later edges are ignored.
    start_rec(0);
    data_limit = 12; cap_mode = 1;
    for (int i = 0; i < 15; i++) edge_gap(80);
    wait_idle();
    chk("cap_len", 32'(rec_len), 32'd12);
    chk("cap_ovf", 32'(overflow), 32'd1);

    // Reset during a header write aborts everything.
    start_rec(0);
    edge_gap(400); edge_gap(400); edge_gap(20);
    stop_rec();
    for (int i = 0; i < 5000 && !(mif.mem_we && mif.mem_addr < BASE + 25'd20); i++) step();
    chk("hdr_we_seen", 32'(mif.mem_we), 32'd1);
    step();
    #2 reset = 1'b1;
    #1;
    chk("arst_we", 32'(mif.mem_we), 32'd0);
    chk("arst_active", 32'(rec_active), 32'd0);
    chk("arst_len", 32'(rec_len), 32'd0);
    exp_q.delete();
    step();
    reset = 1'b0;
    repeat (2) step();

    start_rec(0);
    edge_gap(400); edge_gap(400); edge_gap(20);
    stop_rec(); wait_idle();
    chk("post_rst_len", 32'(rec_len), 32'd2);

    repeat (5) step();
    chk("sb_left", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/tape_rec.md
Name: tape_rec

Overview:
- Cassette recorder: the write-side counterpart of the tape playback block.
- Samples the PET's cass_write line and measures the time between rising edges in 1 MHz CPU ticks.
- Encodes each period as C64 TAP v1 bytes, buffers them in a FIFO, and streams them into SDRAM-backed sram.
- On stop, prepends a 20-byte TAP header so the host can upload the image.

Parameters:
BASE_ADDR, 25'h0, byte address of the TAP image (header) in RAM
MAX_BYTES, 25'h0FFFEC, data byte capacity after the header; reaching it forces stop
FIFO_DEPTH, 8, encoded-byte FIFO entries (power of 2)

Ports:
clk  in  1  system clock (112 MHz)
reset  in  1  asynchronous, active-high
ce_1m  in  1  CPU clock enable; the period measurement tick
cass_write  in  1  PET cassette write line (asynchronous to the tick)
cass_motor_n  in  1  cassette motor, active low
rec_start  in  1  one-clk pulse: begin recording
rec_stop  in  1  one-clk pulse: end recording and write header
mem_addr  out  25  RAM byte address
mem_dout  out  8  RAM write data
mem_we  out  1  write request, held until accepted
mem_ready  in  1  RAM accept strobe (one clk)
rec_active  out  1  high in REC/DRAIN/HDR
rec_len  out  25  data bytes committed to RAM (excludes header)
overflow  out  1  sticky: FIFO push was dropped or capacity was reached

Behaviour:
- Reset values: mem_we=0, mem_addr=0, mem_dout=0, rec_active=0, rec_len=0, overflow=0. State is IDLE and the FIFO is empty.
- Async reset mid-operation aborts immediately. No header is written and any in-flight mem_we drops.
- cass_write passes through a 2-flop synchronizer. A rising edge is detected on the synchronized value in clk.
- Period counter: 24 bits. Increments on each ce_1m while in REC; saturates at 24'hFFFFFF.
- On a rising edge, the counter is captured and restarts from 0 on the same clk. A ce_1m in that same clk counts toward the new period.
- The first edge after rec_start only arms the counter; it produces no byte.
- Encoding of the captured period P, with q=P>>3:
  - 1<=q<=255: push one byte q.
  - q==0: push 8'h01.
  - q>255: push 4 bytes in order: 8'h00, P[7:0], P[15:8], P[23:16].
- Multi-byte pushes: the encoder pushes one byte per clk. A new edge arriving during a push sequence is captured into a 1-entry pending register. A further edge while that register is occupied sets overflow and is dropped.
- FIFO: a push while full is discarded and sets overflow. Pop occurs on the clk mem_ready is sampled high during a data write.
- Memory handshake:
  - mem_we, mem_addr and mem_dout are asserted together and held stable until mem_ready=1 is sampled.
  - mem_we may drop or present the next write on the following clk.
  - Only one outstanding write at a time.
- Data writes go to BASE_ADDR+20+rec_len. rec_len increments on each accepted data write.
- State machine:
  - IDLE: rec_start -> REC. Clears rec_len, overflow, FIFO and counter.
  - REC: rec_stop, or rec_len+FIFO count reaching MAX_BYTES, -> DRAIN. Reaching capacity also sets overflow. Edges after that point are ignored.
  - DRAIN: the FIFO empties to RAM. FIFO empty and no write outstanding -> HDR.
  - HDR: writes 20 bytes to BASE_ADDR+0..19 with the same handshake:
    - bytes 0..11: "C64-TAPE-RAW" (0x43 0x36 0x34 0x2D 0x54 0x41 0x50 0x45 0x2D 0x52 0x41 0x57);
    - byte 12: 0x01;
    - bytes 13..15: 0x00;
    - bytes 16..19: rec_len, little-endian 32 bits, zero-extended.
    - After byte 19 is accepted -> IDLE.
- rec_start outside IDLE and rec_stop outside REC are ignored.
- rec_start and rec_stop in the same clk while in IDLE: start wins. rec_stop is then ignored.

Optional Feature:
TAPE_REC_MOTOR_GATE_EN:
- Defined: the period counter advances only while cass_motor_n=0, and edges are ignored while the motor is off. Motor gaps are therefore excluded from periods, matching real deck behaviour.
- Undefined: cass_motor_n is unused, and the counter runs on every ce_1m in REC.

Test Plan:
- rec_start, then edges 400 ticks apart (arming edge + 2 edges), mem_ready answered after 3 clk -> bytes 0x32, 0x32 at BASE+20 and BASE+21; rec_len=2.
- Single period of 5000 ticks -> bytes 00 88 13 00 at BASE+20..23; rec_len=4.
- Period of 5 ticks -> byte 0x01. Counter held > 2^24 ticks -> 00 FF FF FF.
- 3 periods of 400 ticks then rec_stop -> header written:
  - BASE+0=0x43, BASE+11=0x57, BASE+12=0x01;
  - BASE+16..19 = 03 00 00 00;
  - rec_active falls after the last accept.
- mem_ready withheld while 9 short edges arrive (FIFO_DEPTH=8) -> overflow=1, 8 bytes later written in order, mem_addr/mem_dout stable throughout each hold.
- Assert reset while mem_we is high in HDR -> mem_we=0 asynchronously, state IDLE, rec_len=0. A following rec_start records normally.
